uart_param: RTL and testbench

Parametrised full-duplex UART for the vm1801mini SoC. It provides a programmable bit period, 5–8 data bits, optional parity, 1 or 2 stop bits, a receive FIFO with per-byte error flags, and start-bit glitch rejection. It sits between the board serial pins and the CPU I/O register decoder. It replaces the fixed 8N1 receiver/transmitter pair.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_fifo.sv | 46 ++++
 rtl/uart_param.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_param.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the parametrised UART.
package uart_pkg;

  localparam int unsigned PARITY_NONE  = 0;
  localparam int unsigned PARITY_ODD   = 1;
  localparam int unsigned PARITY_EVEN  = 2;
  localparam int unsigned ENTRY_DATA_W = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // One received character; short data is right-aligned in data.
  typedef struct packed {
    logic                    ferr;
    logic                    perr;
    logic [ENTRY_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; head is presented on rdata while not empty.
module uart_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the simultaneous push needs when full.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_param.sv
// Full-duplex UART: programmable bit period, 5-8 data bits, optional parity,
// 1/2 stop bits, glitch-rejecting receiver feeding an error-tagged RX FIFO.
module uart_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2396,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_send,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_ready,
  input  logic                 rx_read,
  output logic                 rx_overrun,
  input  logic                 rx_clr
);

  localparam int unsigned    CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [2:0]     DBIT_LAST = 3'(DATA_BITS - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic           HAS_PAR   = (PARITY != PARITY_NONE);
  localparam logic           PAR_INV   = (PARITY == PARITY_ODD);

  // ---------------- transmitter ----------------
  tx_state_t              tx_state, tx_state_nxt;
  logic [CNT_W-1:0]       tx_cnt, tx_cnt_nxt;
  logic [2:0]             tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0]   tx_shift, tx_shift_nxt;
  logic                   tx_par, tx_par_nxt;
  logic                   tx_stop, tx_stop_nxt;
  logic                   tx_nxt, tx_busy_nxt;
  logic                   tx_end;

  assign tx_end = (tx_cnt == BIT_LAST);

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_stop_nxt  = tx_stop;
    tx_nxt       = tx;
    tx_busy_nxt  = tx_busy;
    if (tx_state != TX_IDLE) tx_cnt_nxt = tx_end ? '0 : tx_cnt + CNT_W'(1);
    case (tx_state)
      TX_IDLE: if (tx_send) begin
        tx_state_nxt = TX_START;
        tx_shift_nxt = tx_data;
        tx_par_nxt   = (^tx_data) ^ PAR_INV;
        tx_cnt_nxt   = '0;
        tx_nxt       = 1'b0;
        tx_busy_nxt  = 1'b1;
      end
      TX_START: if (tx_end) begin
        tx_state_nxt = TX_DATA;
        tx_bit_nxt   = '0;
        tx_nxt       = tx_shift[0];
      end
      TX_DATA: if (tx_end) begin
        if (tx_bit == DBIT_LAST) begin
          if (HAS_PAR) begin
            tx_state_nxt = TX_PARITY;
            tx_nxt       = tx_par;
          end else begin
            tx_state_nxt = TX_STOP;
            tx_stop_nxt  = 1'b0;
            tx_nxt       = 1'b1;
          end
        end else begin
          tx_bit_nxt   = tx_bit + 3'd1;
          tx_shift_nxt = tx_shift >> 1;
          tx_nxt       = tx_shift[1];
        end
      end
      TX_PARITY: if (tx_end) begin
        tx_state_nxt = TX_STOP;
        tx_stop_nxt  = 1'b0;
        tx_nxt       = 1'b1;
      end
      TX_STOP: if (tx_end) begin
        if (tx_stop == STOP_LAST) begin
          tx_state_nxt = TX_IDLE;
          tx_busy_nxt  = 1'b0;
        end else begin
          tx_stop_nxt = 1'b1;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_stop  <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      tx_par   <= tx_par_nxt;
      tx_stop  <= tx_stop_nxt;
      tx       <= tx_nxt;
      tx_busy  <= tx_busy_nxt;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t              rx_state, rx_state_nxt;
  logic [CNT_W-1:0]       rx_cnt, rx_cnt_nxt;
  logic [2:0]             rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0]   rx_shift, rx_shift_nxt;
  logic                   rx_par, rx_par_nxt;
  logic                   rx_perr_q, rx_perr_nxt;
  logic                   rx_overrun_nxt;
  logic                   rx_s1, rx_s2, rx_prev;
  logic                   rx_fall, rx_tick;
  logic                   push_c, drop_c;
  logic                   fifo_full, fifo_empty;
  rx_entry_t              entry_c, head;

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_tick = (rx_cnt == '0);

  always_comb begin
    rx_state_nxt   = rx_state;
    rx_cnt_nxt     = rx_cnt;
    rx_bit_nxt     = rx_bit;
    rx_shift_nxt   = rx_shift;
    rx_par_nxt     = rx_par;
    rx_perr_nxt    = rx_perr_q;
    push_c         = 1'b0;
    entry_c.ferr   = ~rx_s2;
    entry_c.perr   = rx_perr_q;
    entry_c.data   = ENTRY_DATA_W'(rx_shift);
    if (rx_state != RX_IDLE) rx_cnt_nxt = rx_tick ? BIT_LAST : rx_cnt - CNT_W'(1);
    case (rx_state)
      RX_IDLE: if (rx_fall) begin
        rx_state_nxt = RX_START;
        rx_cnt_nxt   = HALF_LAST;
        rx_par_nxt   = 1'b0;
        rx_perr_nxt  = 1'b0;
      end
      // A start bit that is high again at mid-bit was only a glitch.
      RX_START: if (rx_tick) begin
        rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        rx_bit_nxt   = '0;
      end
      RX_DATA: if (rx_tick) begin
        rx_shift_nxt = {rx_s2, rx_shift[DATA_BITS-1:1]};
        rx_par_nxt   = rx_par ^ rx_s2;
        rx_bit_nxt   = rx_bit + 3'd1;
        if (rx_bit == DBIT_LAST) rx_state_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_tick) begin
        rx_perr_nxt  = rx_par ^ rx_s2 ^ PAR_INV;
        rx_state_nxt = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        push_c       = 1'b1;
        rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
    drop_c         = push_c && fifo_full && !(rx_read && !fifo_empty);
    rx_overrun_nxt = (rx_overrun && !rx_clr) || drop_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par     <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      rx_state   <= rx_state_nxt;
      rx_cnt     <= rx_cnt_nxt;
      rx_bit     <= rx_bit_nxt;
      rx_shift   <= rx_shift_nxt;
      rx_par     <= rx_par_nxt;
      rx_perr_q  <= rx_perr_nxt;
      rx_overrun <= rx_overrun_nxt;
    end
  end

  uart_fifo #(
    .WIDTH($bits(rx_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (rx_read),
    .wdata (entry_c),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_data  = DATA_BITS'(head.data);
  assign rx_perr  = head.perr;
  assign rx_ferr  = head.ferr;
  assign rx_ready = ~fifo_empty;

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: an 8N1 instance (A) and a 7E2 instance (B), both CLK_DIV=16.
module tb_uart_param;

  localparam int DIV = 16;
  typedef bit bitq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic       rx_a, tx_a, tx_send_a, tx_busy_a, rx_perr_a, rx_ferr_a, rx_ready_a;
  logic       rx_read_a, rx_overrun_a, rx_clr_a, line_a, loop_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic       rx_b, tx_b, tx_send_b, tx_busy_b, rx_perr_b, rx_ferr_b, rx_ready_b;
  logic       rx_read_b, rx_overrun_b, rx_clr_b, line_b, loop_b;
  logic [6:0] tx_data_b, rx_data_b;

  assign rx_a = loop_a ? tx_a : line_a;
  assign rx_b = loop_b ? tx_b : line_b;

  uart_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .reset(reset), .clk(clk), .rx(rx_a), .tx(tx_a), .tx_data(tx_data_a), .tx_send(tx_send_a),
    .tx_busy(tx_busy_a), .rx_data(rx_data_a), .rx_perr(rx_perr_a), .rx_ferr(rx_ferr_a),
    .rx_ready(rx_ready_a), .rx_read(rx_read_a), .rx_overrun(rx_overrun_a), .rx_clr(rx_clr_a));

  uart_param #(.CLK_DIV(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .reset(reset), .clk(clk), .rx(rx_b), .tx(tx_b), .tx_data(tx_data_b), .tx_send(tx_send_b),
    .tx_busy(tx_busy_b), .rx_data(rx_data_b), .rx_perr(rx_perr_b), .rx_ferr(rx_ferr_b),
    .rx_ready(rx_ready_b), .rx_read(rx_read_b), .rx_overrun(rx_overrun_b), .rx_clr(rx_clr_b));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line-level picture of one frame, built from the framing rules.
  function automatic void frame_bits(output bitq_t q, input logic [7:0] d, input int nbits,
                                     input int par, input int stops, input bit bad_par,
                                     input bit stop_low);
    int ones;
    ones = 0;
    q = {};
    q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par != 0) q.push_back(bit'(((ones % 2) == 1) != (par == 1)) ^ bad_par);
    for (int s = 0; s < stops; s++) q.push_back(!(s == 0 && stop_low));
  endfunction

  function automatic logic ready_of(input int inst);
    return (inst == 0) ? rx_ready_a : rx_ready_b;
  endfunction

  // Drive a frame on an rx line; optionally pulse rx_read at negedge pop_at.
  task automatic drive_frame(input int inst, input logic [7:0] d, input bit bad_par,
                             input bit stop_low, input int pop_at, output int rdy_at);
    bitq_t q;
    logic  prev, cur, b;
    if (inst == 0) frame_bits(q, d, 8, 0, 1, bad_par, stop_low);
    else           frame_bits(q, d, 7, 2, 2, bad_par, stop_low);
    rdy_at = -1;
    prev = ready_of(inst);
    for (int k = 0; k < q.size() * DIV + 4; k++) begin
      @(negedge clk);
      cur = ready_of(inst);
      if (cur && !prev && rdy_at < 0) rdy_at = k;
      prev = cur;
      b = (k < q.size() * DIV) ? q[k / DIV] : 1'b1;
      if (inst == 0) begin line_a = b; rx_read_a = (k == pop_at); end
      else           begin line_b = b; rx_read_b = (k == pop_at); end
    end
    @(negedge clk);
    rx_read_a = 1'b0;
    rx_read_b = 1'b0;
  endtask

  task automatic pop_check(input int inst, input string name, input logic [7:0] d,
                           input bit p, input bit f);
    if (inst == 0) begin
      check({name, "_rdy"}, rx_ready_a, 1);
      check({name, "_data"}, rx_data_a, d);
      check({name, "_perr"}, rx_perr_a, p);
      check({name, "_ferr"}, rx_ferr_a, f);
      rx_read_a = 1'b1;
      @(negedge clk);
      rx_read_a = 1'b0;
    end else begin
      check({name, "_rdy"}, rx_ready_b, 1);
      check({name, "_data"}, rx_data_b, d);
      check({name, "_perr"}, rx_perr_b, p);
      check({name, "_ferr"}, rx_ferr_b, f);
      rx_read_b = 1'b1;
      @(negedge clk);
      rx_read_b = 1'b0;
    end
  endtask

  task automatic wait_ready(input int inst, input int budget, output int waited);
    waited = 0;
    while (ready_of(inst) !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check("rx_ready_timeout", ready_of(inst), 1);
  endtask

  // Send on A and compare tx/tx_busy every cycle; optionally retry mid-frame.
  task automatic tx_frame_check(input logic [7:0] d, input bit resend);
    bitq_t q;
    frame_bits(q, d, 8, 0, 1, 1'b0, 1'b0);
    @(negedge clk);
    tx_data_a = d;
    tx_send_a = 1'b1;
    @(negedge clk);
    tx_send_a = 1'b0;
    for (int k = 0; k < 10 * DIV + 20; k++) begin
      check("tx_line", tx_a, (k < 10 * DIV) ? q[k / DIV] : 1'b1);
      check("tx_busy", tx_busy_a, k < 10 * DIV);
      if (resend && k == 40) begin
        tx_data_a = 8'hFF;
        tx_send_a = 1'b1;
      end else tx_send_a = 1'b0;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [6:0] d;
    bit         bad_par;
    bit         stop_low;
    logic [6:0] exp_d;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t         tbl[6];
  logic [9:0]   mq[$];
  logic [9:0]   e;
  logic [7:0]   d;
  logic [7:0]   sent[$];
  bit           m_ovr, sl;
  int           r, lat, waited, npop;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    line_a = 1'b1; loop_a = 1'b0; tx_send_a = 1'b0; tx_data_a = '0; rx_read_a = 1'b0; rx_clr_a = 1'b0;
    line_b = 1'b1; loop_b = 1'b0; tx_send_b = 1'b0; tx_data_b = '0; rx_read_b = 1'b0; rx_clr_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_a", tx_a, 1);
    check("rst_busy_a", tx_busy_a, 0);
    check("rst_ready_a", rx_ready_a, 0);
    check("rst_data_a", rx_data_a, 0);
    check("rst_perr_a", rx_perr_a, 0);
    check("rst_ferr_a", rx_ferr_a, 0);
    check("rst_ovr_a", rx_overrun_a, 0);
    check("rst_tx_b", tx_b, 1);
    check("rst_ready_b", rx_ready_b, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    tx_frame_check(8'hA5, 1'b0);
    tx_frame_check(8'h3C, 1'b1);

    // Back-to-back: a send in the cycle after tx_busy falls is accepted.
    tx_data_a = 8'h0F; tx_send_a = 1'b1;
    @(negedge clk);
    tx_send_a = 1'b0;
    repeat (10 * DIV - 1) @(negedge clk);
    check("chain_last_busy", tx_busy_a, 1);
    @(negedge clk);
    check("chain_gap_busy", tx_busy_a, 0);
    check("chain_gap_tx", tx_a, 1);
    tx_data_a = 8'hF0; tx_send_a = 1'b1;
    @(negedge clk);
    tx_send_a = 1'b0;
    check("chain_start_busy", tx_busy_a, 1);
    check("chain_start_tx", tx_a, 0);
    for (int i = 0; i < 400 && tx_busy_a; i++) @(negedge clk);
    check("chain_done", tx_busy_a, 0);

    // 7E2 loopback with latency window.
    loop_b = 1'b1;
    @(negedge clk);
    tx_data_b = 7'h55; tx_send_b = 1'b1;
    @(negedge clk);
    tx_send_b = 1'b0;
    wait_ready(1, 400, lat);
    check("lb_latency_window", (lat >= 154 && lat <= 156), 1);
    pop_check(1, "lb", 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 400 && tx_busy_b; i++) @(negedge clk);
    check("lb_tx_done", tx_busy_b, 0);
    loop_b = 1'b0;
    repeat (4) @(negedge clk);

    // Table of 7E2 frames with corrupted parity / stop bits.
    tbl[0] = '{7'h55, 1'b0, 1'b0, 7'h55, 1'b0, 1'b0};
    tbl[1] = '{7'h55, 1'b1, 1'b0, 7'h55, 1'b1, 1'b0};
    tbl[2] = '{7'h7F, 1'b0, 1'b1, 7'h7F, 1'b0, 1'b1};
    tbl[3] = '{7'h00, 1'b1, 1'b1, 7'h00, 1'b1, 1'b1};
    tbl[4] = '{7'h2A, 1'b0, 1'b0, 7'h2A, 1'b0, 1'b0};
    tbl[5] = '{7'h13, 1'b1, 1'b0, 7'h13, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive_frame(1, {1'b0, tbl[i].d}, tbl[i].bad_par, tbl[i].stop_low, -1, r);
      pop_check(1, "tbl", {1'b0, tbl[i].exp_d}, tbl[i].exp_perr, tbl[i].exp_ferr);
      check("tbl_empty", rx_ready_b, 0);
    end

    // Short low pulse is rejected; a bad stop bit is tagged.
    line_a = 1'b0;
    repeat (5) @(negedge clk);
    line_a = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_ready", rx_ready_a, 0);
    drive_frame(0, 8'hC3, 1'b0, 1'b1, -1, r);
    pop_check(0, "ferr", 8'hC3, 1'b0, 1'b1);

    // Overrun: 5 frames into a 4-deep FIFO.
    sent = {};
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      sent.push_back(d);
      drive_frame(0, d, 1'b0, 1'b0, -1, r);
      if (i == 0) lat = r;
      if (i == 3) check("ovr_not_yet", rx_overrun_a, 0);
    end
    check("ovr_latency_window", (lat >= 154 && lat <= 156), 1);
    check("ovr_set", rx_overrun_a, 1);
    for (int i = 0; i < 4; i++) pop_check(0, "ovr_pop", sent[i], 1'b0, 1'b0);
    check("ovr_drained", rx_ready_a, 0);
    rx_read_a = 1'b1;
    @(negedge clk);
    rx_read_a = 1'b0;
    check("pop_empty_ignored", rx_ready_a, 0);
    check("ovr_sticky", rx_overrun_a, 1);
    rx_clr_a = 1'b1;
    @(negedge clk);
    rx_clr_a = 1'b0;
    check("ovr_cleared", rx_overrun_a, 0);

    // Full FIFO: pop in the same cycle as the push -> no overrun.
    sent = {};
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      sent.push_back(d);
      drive_frame(0, d, 1'b0, 1'b0, (i == 4) ? lat - 1 : -1, r);
    end
    check("fullpop_no_ovr", rx_overrun_a, 0);
    for (int i = 1; i < 5; i++) pop_check(0, "fullpop", sent[i], 1'b0, 1'b0);
    check("fullpop_drained", rx_ready_a, 0);

    // Randomised frames and reads against a queue model.
    mq = {};
    m_ovr = 1'b0;
    for (int it = 0; it < 24; it++) begin
      d  = 8'($urandom);
      sl = ($urandom_range(0, 4) == 0);
      drive_frame(0, d, 1'b0, sl, -1, r);
      if (mq.size() < 4) mq.push_back({sl, 1'b0, d});
      else m_ovr = 1'b1;
      check("rand_ovr", rx_overrun_a, m_ovr);
      check("rand_rdy", rx_ready_a, mq.size() != 0);
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop && mq.size() > 0; j++) begin
        e = mq.pop_front();
        pop_check(0, "rand", e[7:0], e[8], e[9]);
      end
      if ($urandom_range(0, 5) == 0) begin
        rx_clr_a = 1'b1;
        @(negedge clk);
        rx_clr_a = 1'b0;
        m_ovr = 1'b0;
      end
    end
    while (mq.size() > 0) begin
      e = mq.pop_front();
      pop_check(0, "rand_drain", e[7:0], e[8], e[9]);
    end
    check("rand_empty", rx_ready_a, 0);

    // Reset in the middle of both a TX and an RX frame.
    drive_frame(0, 8'h99, 1'b0, 1'b0, -1, r);
    check("pre_rst_ready", rx_ready_a, 1);
    loop_a = 1'b1;
    tx_data_a = 8'h81; tx_send_a = 1'b1;
    @(negedge clk);
    tx_send_a = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_busy", tx_busy_a, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_tx_async", tx_a, 1);
    check("mid_rst_busy", tx_busy_a, 0);
    check("mid_rst_ready", rx_ready_a, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tx_data_a = 8'h5A; tx_send_a = 1'b1;
    @(negedge clk);
    tx_send_a = 1'b0;
    wait_ready(0, 400, waited);
    pop_check(0, "post_rst", 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 400 && tx_busy_a; i++) @(negedge clk);
    check("post_rst_empty", rx_ready_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
